// File: rtl/weight_fetch_seq.sv
// weight_fetch_seq
//   Read-side sequencer for a per-layer 32-bank weight ROM. Drives the ROM
//   address, tracks the ROM's one-cycle registered read latency with a two
//   stage valid pipeline, and buffers returned weight vectors in a 4-entry
//   FIFO (registered head plus 3 backing entries) presented to the PE array
//   over a valid/ready stream.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      pulse, begins a pass when idle
//   loops      (WFETCH_LOOP_EN only) extra sweeps, sampled with start
//   last_addr  final address of the pass, sampled on accepted start
//   rom_addr   registered ROM address
//   rom_data   ROM registered output, valid one cycle after rom_addr
//   w_valid / w_ready / w_data / w_last   weight vector stream to PE array
//   busy       pass in progress
//   done       one-cycle pulse when the last-tagged vector has handshaken
//
// Configuration
//   WFETCH_LOOP_EN  when defined, adds the 8-bit `loops` input: the pass
//                   re-sweeps 0..last_addr loops+1 times back-to-back.

module weight_fetch_seq #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 10,
  parameter int NUM   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
`ifdef WFETCH_LOOP_EN
  input  logic [7:0]                loops,
`endif
  input  logic [ADDR-1:0]           last_addr,
  output logic [ADDR-1:0]           rom_addr,
  input  logic [0:NUM-1][WIDTH-1:0] rom_data,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [0:NUM-1][WIDTH-1:0] w_data,
  output logic                      w_last,
  output logic                      busy,
  output logic                      done
);

  localparam int VW = WIDTH * NUM;
  localparam int QD = 3;  // backing entries behind the head register

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [ADDR-1:0] rom_addr_reg, last_reg;
  logic            v1_reg, v2_reg, l1_reg, l2_reg;
  logic            busy_reg, done_reg;
  logic [7:0]      loops_in, loops_reg;

  logic            head_valid_reg, head_last_reg;
  logic [VW-1:0]   head_data_reg;
  logic [1:0]      q_cnt_reg;
  logic [VW:0]     q_ent [0:QD-1];

  logic            pop, push, q_push, head_load, q_shift;
  logic            at_end, final_addr, credit_ok;
  logic [3:0]      occ;
  logic [VW:0]     push_ent;

  logic            issue, issue_last, loop_wrap, finish;
  logic [ADDR-1:0] issue_addr;
  logic [7:0]      loops_after;

`ifdef WFETCH_LOOP_EN
  assign loops_in = loops;
`else
  assign loops_in = 8'd0;
`endif

  assign pop       = head_valid_reg & w_ready;
  assign push      = v2_reg;
  assign push_ent  = {l2_reg, rom_data};
  assign head_load = !head_valid_reg || pop;
  assign q_shift   = head_load && (q_cnt_reg != 2'd0);
  // A push bypasses the queue only when the head is being refilled from empty.
  assign q_push    = push && !(head_load && (q_cnt_reg == 2'd0));

  // Credit: everything stored plus everything in flight from the ROM must fit
  // in the 4 entries after this cycle's issue.
  assign occ        = 4'(q_cnt_reg) + 4'(head_valid_reg) + 4'(v1_reg) + 4'(v2_reg) - 4'(pop);
  assign credit_ok  = occ < 4'd4;
  assign at_end     = rom_addr_reg == last_reg;
  assign final_addr = at_end && (loops_reg == 8'd0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (final_addr) state_next = DRAIN;
      DRAIN:   if (pop && head_last_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (issue control) ----------------
  // rom_addr always holds the most recently issued address, so an issue in
  // RUN targets rom_addr+1 (or 0 when another sweep begins).
  always_comb begin
    issue       = 1'b0;
    issue_addr  = rom_addr_reg;
    issue_last  = 1'b0;
    loop_wrap   = 1'b0;
    finish      = 1'b0;
    loops_after = loops_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          issue      = 1'b1;
          issue_addr = '0;
          issue_last = (last_addr == '0) && (loops_in == 8'd0);
        end
      end
      RUN: begin
        if (!final_addr && credit_ok) begin
          issue       = 1'b1;
          loop_wrap   = at_end;
          issue_addr  = at_end ? '0 : rom_addr_reg + 1'b1;
          loops_after = at_end ? loops_reg - 8'd1 : loops_reg;
          issue_last  = (issue_addr == last_reg) && (loops_after == 8'd0);
        end
      end
      DRAIN:   finish = pop && head_last_reg;
      default: ;
    endcase
  end

  // ---------------- Address / latency pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_reg <= '0;
      last_reg     <= '0;
      loops_reg    <= 8'd0;
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      l1_reg       <= 1'b0;
      l2_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      if (issue) rom_addr_reg <= issue_addr;
      if (state_reg == IDLE && start) begin
        last_reg  <= last_addr;
        loops_reg <= loops_in;
      end else if (loop_wrap) begin
        loops_reg <= loops_reg - 8'd1;
      end
      // v1: rom_addr is a fresh issue; v2: rom_data carries that word now.
      v1_reg   <= issue;
      l1_reg   <= issue_last;
      v2_reg   <= v1_reg;
      l2_reg   <= l1_reg;
      busy_reg <= (state_next != IDLE);
      done_reg <= finish;
    end
  end

  // ---------------- FIFO backing entries (shift queue) ----------------
  genvar gi;
  for (gi = 0; gi < QD; gi++) begin : g_q
    logic [VW:0] ent_reg, ent_next, upper;
    if (gi < QD - 1) begin : g_mid
      assign upper = q_ent[gi+1];
    end else begin : g_top
      assign upper = ent_reg;
    end
    always_comb begin
      ent_next = q_shift ? upper : ent_reg;
      if (q_push && (gi == int'(q_cnt_reg) - int'(q_shift))) ent_next = push_ent;
    end
    always_ff @(posedge clk) begin
      if (rst) ent_reg <= '0;
      else     ent_reg <= ent_next;
    end
    assign q_ent[gi] = ent_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) q_cnt_reg <= 2'd0;
    else     q_cnt_reg <= q_cnt_reg + 2'(q_push) - 2'(q_shift);
  end

  // ---------------- FIFO head register ----------------
  // Head data/last are only reloaded with a real entry, so they hold the
  // previous vector while w_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_reg <= 1'b0;
      head_last_reg  <= 1'b0;
      head_data_reg  <= '0;
    end else if (head_load) begin
      if (q_cnt_reg != 2'd0) begin
        {head_last_reg, head_data_reg} <= q_ent[0];
        head_valid_reg <= 1'b1;
      end else if (push) begin
        {head_last_reg, head_data_reg} <= push_ent;
        head_valid_reg <= 1'b1;
      end else begin
        head_valid_reg <= 1'b0;
      end
    end
  end

  assign rom_addr = rom_addr_reg;
  assign w_valid  = head_valid_reg;
  assign w_data   = head_data_reg;
  assign w_last   = head_last_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule
